// File: rtl/mem_responder_if.sv
// Request/acknowledge bus between a memory initiator and the mem_responder.
// Latency: none (wires only); master drives req/we/addr/wdata, slave drives ack/rdata/err/busy.
// Backpressure: the initiator holds req and its payload until it samples ack=1.
interface mem_responder_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              ack;
  logic [DATA_W-1:0] rdata;
  logic              err;
  logic              busy;

  modport master (
    output req, we, addr, wdata,
    input  ack, rdata, err, busy
  );

  modport slave (
    input  req, we, addr, wdata,
    output ack, rdata, err, busy
  );
endinterface

// File: rtl/mem_responder.sv
// Single-beat memory responder: DEPTH x DATA_W array, zero-swept after every reset.
// Latency: write/range-error ack 1 cycle after acceptance, read ack RD_LAT cycles after.
// Backpressure: busy=1 outside IDLE; req is only sampled in IDLE, one transaction in flight.
// Ports: clk, rst_n (async active-low); bus (slave modport): req/we/addr/wdata in,
//        ack (1-cycle pulse), rdata (held after ack), err (valid with ack), busy out.
module mem_responder #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 256,
  parameter int RD_LAT = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  mem_responder_if.slave  bus
);

  localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W  = (RD_LAT > 2) ? $clog2(RD_LAT) : 1;

  localparam logic [1:0] S_INIT    = 2'd0;
  localparam logic [1:0] S_IDLE    = 2'd1;
  localparam logic [1:0] S_RD_WAIT = 2'd2;
  localparam logic [1:0] S_ACK     = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;

  logic [DATA_W-1:0] mem [DEPTH];
  logic              mem_we;
  logic [MEM_AW-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdat;
  logic              in_range;

  // One extra bit so DEPTH == 2**ADDR_W compares correctly.
  assign in_range = ({1'b0, bus.addr} < (ADDR_W+1)'(DEPTH));

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    mem_we    = 1'b0;
    mem_waddr = bus.addr[MEM_AW-1:0];
    mem_wdat  = bus.wdata;
    case (state_q)
      S_INIT: begin
        // Sweep shares the single write port; req is ignored meanwhile.
        mem_we    = 1'b1;
        mem_waddr = ptr_q[MEM_AW-1:0];
        mem_wdat  = '0;
        ptr_d     = ptr_q + 1'b1;
        if (ptr_q == ADDR_W'(DEPTH - 1)) state_d = S_IDLE;
      end
      S_IDLE: begin
        if (bus.req) begin
          if (!in_range) begin
            err_d = 1'b1;
            if (!bus.we) rdata_d = '0;
            state_d = S_ACK;
          end else if (bus.we) begin
            mem_we  = 1'b1;
            state_d = S_ACK;
          end else if (RD_LAT == 1) begin
            rdata_d = mem[bus.addr[MEM_AW-1:0]];
            state_d = S_ACK;
          end else begin
            addr_d  = bus.addr;
            cnt_d   = CNT_W'(RD_LAT - 1);
            state_d = S_RD_WAIT;
          end
        end
      end
      S_RD_WAIT: begin
        // Leave when the counter reaches zero so ack lands RD_LAT cycles after acceptance.
        cnt_d = cnt_q - 1'b1;
        if (cnt_d == '0) begin
          rdata_d = mem[addr_q[MEM_AW-1:0]];
          state_d = S_ACK;
        end
      end
      S_ACK: begin
        err_d   = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_INIT;
      ptr_q   <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Storage carries no reset; the INIT sweep provides the zero contents.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdat;
  end

  assign bus.ack   = (state_q == S_ACK);
  assign bus.busy  = (state_q != S_IDLE);
  assign bus.err   = err_q;
  assign bus.rdata = rdata_q;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: a DEPTH=256 and a DEPTH=128 instance, table vectors,
// hand sequences for back-to-back / RD_WAIT toggling / mid-read reset, and random traffic.
// Latency: n/a. Backpressure: each transaction waits for busy=0 before asserting req.
module tb_mem_responder;
  localparam int AW = 8;
  localparam int DW = 16;
  localparam int RL = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] model_a [256];
  logic [DW-1:0] model_b [128];

  mem_responder_if #(.ADDR_W(AW), .DATA_W(DW)) bif_a ();
  mem_responder_if #(.ADDR_W(AW), .DATA_W(DW)) bif_b ();

  mem_responder #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(256), .RD_LAT(RL)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(bif_a.slave)
  );
  mem_responder #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(128), .RD_LAT(RL)) u_dut128 (
    .clk(clk), .rst_n(rst_n), .bus(bif_b.slave)
  );

  typedef struct {
    bit          sel;
    bit          we;
    logic [7:0]  addr;
    logic [15:0] wdata;
    logic [15:0] exp_rdata;
    bit          exp_err;
    int          exp_lat;
  } vec_t;

  vec_t vt [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input bit sel, input logic r, input logic w,
                       input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (sel == 1'b0) begin
      bif_a.req = r; bif_a.we = w; bif_a.addr = a; bif_a.wdata = d;
    end else begin
      bif_b.req = r; bif_b.we = w; bif_b.addr = a; bif_b.wdata = d;
    end
  endtask

  task automatic sample(input bit sel, output logic ack, output logic [DW-1:0] rd,
                        output logic er, output logic busy);
    if (sel == 1'b0) begin
      ack = bif_a.ack; rd = bif_a.rdata; er = bif_a.err; busy = bif_a.busy;
    end else begin
      ack = bif_b.ack; rd = bif_b.rdata; er = bif_b.err; busy = bif_b.busy;
    end
  endtask

  // Returns on a falling edge with the selected DUT idle.
  task automatic wait_idle(input bit sel);
    logic ack, er, busy;
    logic [DW-1:0] rd;
    bit seen = 1'b0;
    for (int i = 0; i < 1000 && !seen; i++) begin
      @(negedge clk);
      sample(sel, ack, rd, er, busy);
      if (!busy) seen = 1'b1;
    end
    chk("idle_seen", 32'(seen), 32'd1);
  endtask

  // One transaction; lat = number of rising edges from the accepting edge up to ack.
  task automatic txn(input bit sel, input logic we, input logic [AW-1:0] a,
                     input logic [DW-1:0] d, output logic [DW-1:0] rdo,
                     output logic ero, output int lat);
    logic ack, er, busy;
    logic [DW-1:0] rd;
    bit got = 1'b0;
    rdo = '0; ero = 1'b0; lat = 0;
    wait_idle(sel);
    drive(sel, 1'b1, we, a, d);
    for (int i = 1; i <= 16 && !got; i++) begin
      @(posedge clk); #1;
      sample(sel, ack, rd, er, busy);
      if (ack) begin
        got = 1'b1; lat = i; rdo = rd; ero = er;
      end
    end
    drive(sel, 1'b0, we, a, d);
    chk("ack_seen", 32'(got), 32'd1);
  endtask

  // Releases reset on a falling edge and checks the INIT sweep length of both DUTs.
  task automatic release_and_time_init();
    int ca = 0, cb = 0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 1; n <= 300; n++) begin
      @(posedge clk); #1;
      if (!bif_a.busy && ca == 0) ca = n;
      if (!bif_b.busy && cb == 0) cb = n;
    end
    chk("init_cycles_256", 32'(ca), 32'd256);
    chk("init_cycles_128", 32'(cb), 32'd128);
    for (int i = 0; i < 256; i++) model_a[i] = '0;
    for (int i = 0; i < 128; i++) model_b[i] = '0;
  endtask

  initial begin
    logic [DW-1:0] rd;
    logic er;
    int lat;

    vt[0]  = '{1'b0, 1'b0, 8'h55, 16'h0000, 16'h0000, 1'b0, RL};
    vt[1]  = '{1'b0, 1'b1, 8'h10, 16'h1234, 16'h0000, 1'b0, 1};
    vt[2]  = '{1'b0, 1'b1, 8'h20, 16'hABCD, 16'h0000, 1'b0, 1};
    vt[3]  = '{1'b0, 1'b0, 8'h10, 16'h0000, 16'h1234, 1'b0, RL};
    vt[4]  = '{1'b0, 1'b0, 8'h20, 16'h0000, 16'hABCD, 1'b0, RL};
    vt[5]  = '{1'b0, 1'b1, 8'hFF, 16'h0F0F, 16'h0000, 1'b0, 1};
    vt[6]  = '{1'b0, 1'b0, 8'hFF, 16'h0000, 16'h0F0F, 1'b0, RL};
    vt[7]  = '{1'b1, 1'b1, 8'h10, 16'h5A5A, 16'h0000, 1'b0, 1};
    vt[8]  = '{1'b1, 1'b1, 8'h90, 16'hFFFF, 16'h0000, 1'b1, 1};
    vt[9]  = '{1'b1, 1'b0, 8'h10, 16'h0000, 16'h5A5A, 1'b0, RL};
    vt[10] = '{1'b1, 1'b0, 8'h90, 16'h0000, 16'h0000, 1'b1, 1};
    vt[11] = '{1'b1, 1'b1, 8'h7F, 16'h7777, 16'h0000, 1'b0, 1};
    vt[12] = '{1'b1, 1'b0, 8'h7F, 16'h0000, 16'h7777, 1'b0, RL};
    vt[13] = '{1'b1, 1'b0, 8'h80, 16'h0000, 16'h0000, 1'b1, 1};

    drive(1'b0, 1'b0, 1'b0, '0, '0);
    drive(1'b1, 1'b0, 1'b0, '0, '0);

    // Reset values while rst_n is low.
    repeat (3) @(negedge clk);
    chk("rst_ack",   32'(bif_a.ack),   32'd0);
    chk("rst_err",   32'(bif_a.err),   32'd0);
    chk("rst_rdata", 32'(bif_a.rdata), 32'd0);
    chk("rst_busy",  32'(bif_a.busy),  32'd1);
    chk("rst_busy_128", 32'(bif_b.busy), 32'd1);
    release_and_time_init();

    // Table vectors.
    for (int i = 0; i < 14; i++) begin
      txn(vt[i].sel, vt[i].we, vt[i].addr, vt[i].wdata, rd, er, lat);
      chk($sformatf("vec%0d_err", i), 32'(er), 32'(vt[i].exp_err));
      chk($sformatf("vec%0d_lat", i), 32'(lat), 32'(vt[i].exp_lat));
      if (!vt[i].we) chk($sformatf("vec%0d_rdata", i), 32'(rd), 32'(vt[i].exp_rdata));
      if (vt[i].we && !vt[i].exp_err) begin
        if (vt[i].sel == 1'b0) model_a[vt[i].addr] = vt[i].wdata;
        else                   model_b[vt[i].addr[6:0]] = vt[i].wdata;
      end
    end

    // Back-to-back: write 0x30, req held straight into a read of 0x30.
    begin
      int first = 0, acks = 0, wlat = 0;
      logic [DW-1:0] got_rd = '0;
      wait_idle(1'b0);
      drive(1'b0, 1'b1, 1'b1, 8'h30, 16'hBEEF);
      for (int i = 1; i <= 8 && wlat == 0; i++) begin
        @(posedge clk); #1;
        if (bif_a.ack) wlat = i;
      end
      chk("b2b_write_lat", 32'(wlat), 32'd1);
      drive(1'b0, 1'b1, 1'b0, 8'h30, 16'h0000);
      for (int i = 1; i <= 8; i++) begin
        @(posedge clk); #1;
        if (bif_a.ack) begin
          acks++;
          if (first == 0) begin
            first = i; got_rd = bif_a.rdata;
          end
          drive(1'b0, 1'b0, 1'b0, 8'h30, 16'h0000);
        end
      end
      drive(1'b0, 1'b0, 1'b0, 8'h30, 16'h0000);
      chk("b2b_read_acks", 32'(acks), 32'd1);
      chk("b2b_read_edge", 32'(first), 32'(RL + 1));
      chk("b2b_read_rdata", 32'(got_rd), 32'hBEEF);
      model_a[8'h30] = 16'hBEEF;
    end

    // req/addr toggled during RD_WAIT: latched 0x10 must be used, one ack.
    begin
      int first = 0, acks = 0;
      logic [DW-1:0] got_rd = '0;
      wait_idle(1'b0);
      drive(1'b0, 1'b1, 1'b0, 8'h10, 16'h0000);
      @(posedge clk); #1;
      chk("tog_ack_in_wait", 32'(bif_a.ack), 32'd0);
      drive(1'b0, 1'b0, 1'b0, 8'h20, 16'h0000);
      #2 drive(1'b0, 1'b1, 1'b0, 8'h20, 16'h0000);
      for (int i = 1; i <= 8; i++) begin
        if (i > 1) begin
          @(posedge clk); #1;
        end
        if (bif_a.ack) begin
          acks++;
          if (first == 0) begin
            first = i; got_rd = bif_a.rdata;
          end
          drive(1'b0, 1'b0, 1'b0, 8'h20, 16'h0000);
        end
        if (i == 1) begin
          @(posedge clk); #1;
          if (bif_a.ack) begin
            acks++; first = 1; got_rd = bif_a.rdata;
            drive(1'b0, 1'b0, 1'b0, 8'h20, 16'h0000);
          end
        end
      end
      drive(1'b0, 1'b0, 1'b0, 8'h20, 16'h0000);
      chk("tog_acks", 32'(acks), 32'd1);
      chk("tog_rdata", 32'(got_rd), 32'(model_a[8'h10]));
    end

    // Randomized traffic against the array model.
    for (int k = 0; k < 150; k++) begin
      bit s, w, exp_err;
      logic [AW-1:0] a;
      logic [DW-1:0] d, exp_rd;
      int depth;
      s = 1'($urandom_range(0, 1));
      w = 1'($urandom_range(0, 1));
      a = AW'($urandom_range(0, 255));
      d = DW'($urandom);
      depth = s ? 128 : 256;
      exp_err = (int'(a) >= depth);
      if (exp_err)          exp_rd = '0;
      else if (s == 1'b0)   exp_rd = model_a[a];
      else                  exp_rd = model_b[a[6:0]];
      txn(s, w, a, d, rd, er, lat);
      chk($sformatf("rnd%0d_err", k), 32'(er), 32'(exp_err));
      chk($sformatf("rnd%0d_lat", k), 32'(lat), (w || exp_err) ? 32'd1 : 32'(RL));
      if (!w) chk($sformatf("rnd%0d_rdata", k), 32'(rd), 32'(exp_rd));
      if (w && !exp_err) begin
        if (s == 1'b0) model_a[a] = d;
        else           model_b[a[6:0]] = d;
      end
    end

    // Reset asserted during RD_WAIT: ack stays low, sweep reruns, data cleared.
    begin
      int acks = 0;
      wait_idle(1'b0);
      drive(1'b0, 1'b1, 1'b0, 8'h10, 16'h0000);
      @(posedge clk); #1;
      chk("mid_rst_in_wait_busy", 32'(bif_a.busy), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_ack", 32'(bif_a.ack), 32'd0);
      chk("mid_rst_err", 32'(bif_a.err), 32'd0);
      drive(1'b0, 1'b0, 1'b0, 8'h10, 16'h0000);
      for (int i = 0; i < 4; i++) begin
        @(posedge clk); #1;
        if (bif_a.ack) acks++;
      end
      chk("mid_rst_no_ack", 32'(acks), 32'd0);
      release_and_time_init();
      txn(1'b0, 1'b0, 8'h10, 16'h0000, rd, er, lat);
      chk("post_rst_rdata", 32'(rd), 32'd0);
      chk("post_rst_err", 32'(er), 32'd0);
      txn(1'b1, 1'b0, 8'h10, 16'h0000, rd, er, lat);
      chk("post_rst_rdata_128", 32'(rd), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
